mines_board_engine: RTL
=======================

Name: mines_board_engine

Overview:
- Parametrised successor to the fixed 5x5 minesweeper datapath: a generic ROWS x COLS board engine.
- Latches a mine bitmap from the RNG stage, accepts one guess at a time, and supports flag/unflag mode.
- Counts all 8 neighbours sequentially with edge clipping, tracks the cleared mask and score, and detects loss and win.
- Sits between the RNG/mine-placement block and the display block, replacing the decode/ALU pair.

Parameters:
- ROWS, 5, board rows; legal range 2..16.
- COLS, 5, board columns; legal range 2..16.
- SCORE_W, 32, score counter width.
- Derived localparams: N = ROWS*COLS; IDX_W = $clog2(N).
- Cell index i = row*COLS + col; bit i of every board vector refers to cell i.

Ports:
- in_clka  input  1  sole clock; all state changes on its rising edge.
- in_restart  input  1  synchronous active-high reset.
- in_place  input  1  load in_mines and start a new game (honoured in IDLE, WAIT, LOST, WON).
- in_mines  input  N  mine bitmap, sampled when in_place is accepted.
- in_data_in  input  1  guess valid; one-cycle strobe, sampled only in WAIT.
- in_data  input  IDX_W  guessed cell index.
- in_flag  input  1  qualifies in_data_in: 1 = toggle flag, 0 = reveal.
- out_state  output  3  IDLE=0, WAIT=1, CHECK=2, SCAN=3, REPORT=4, LOST=5, WON=6.
- out_ready  output  1  high only in WAIT.
- out_mines  output  N  latched mine map.
- out_cleared  output  N  revealed-cell mask.
- out_flagged  output  N  flag mask.
- out_n_nearby  output  4  neighbour-mine count of the last revealed cell (0..8).
- out_n_valid  output  1  one-cycle pulse in REPORT.
- out_err  output  1  one-cycle pulse on a rejected guess.
- out_score  output  SCORE_W  number of safe cells revealed.
- out_gameover  output  1  high in LOST.
- out_win  output  1  high in WON.

Behaviour:
- Reset: in_restart=1 at an edge forces IDLE from any state, including mid-SCAN.
  - All outputs are 0 after reset; all internal registers are cleared.
  - in_restart has priority over in_place and in_data_in.
- IDLE: wait for in_place.
  - On in_place: latch out_mines=in_mines and mine_total=popcount(in_mines).
  - Clear out_cleared, out_flagged, out_score and out_n_nearby.
  - If mine_total==N go to WON; otherwise go to WAIT.
- WAIT: in_place takes priority over in_data_in and reloads the board exactly as from IDLE.
- WAIT, in_data_in=1 with in_flag=1:
  - If in_data>=N or the cell is cleared: out_err pulses next cycle.
  - Otherwise out_flagged[in_data] toggles.
  - Stay in WAIT in both cases.
- WAIT, in_data_in=1 with in_flag=0:
  - If in_data>=N, or the cell is cleared, or the cell is flagged: out_err pulses, no other change, stay in WAIT.
  - Otherwise latch idx and go to CHECK.
- CHECK, 1 cycle:
  - Mine at idx: set out_cleared[idx] and go to LOST; score is unchanged.
  - No mine: set out_cleared[idx], out_score+=1, clear the neighbour accumulator, set k=0, go to SCAN.
- SCAN, exactly 8 cycles, k=0..7. Offsets (dr,dc) in order: (-1,-1), (-1,0), (-1,1), (0,-1), (0,1), (1,-1), (1,0), (1,1).
  - Each cycle the accumulator increments if row+dr is in 0..ROWS-1, col+dc is in 0..COLS-1, and that cell is a mine.
  - There is no wrap across row ends or board edges.
  - After k=7 go to REPORT.
- REPORT, 1 cycle: out_n_nearby=count, out_n_valid=1.
  - Next state is WON if out_score==N-mine_total, else WAIT.
- Latency: guess accepted at edge E0 → CHECK in cycle 1 → SCAN in cycles 2–9 → REPORT in cycle 10 → WAIT (out_ready=1) in cycle 11.
  - in_data_in outside WAIT is ignored, with no out_err.
  - in_place in CHECK, SCAN or REPORT is ignored.
- LOST and WON are terminal: hold every output.
  - out_gameover=1 in LOST; out_win=1 in WON.
  - Exit only via in_place (new game, as from IDLE) or in_restart.
- Score saturates at all-ones; this is unreachable for legal ROWS/COLS.
- out_n_nearby holds its value until the next REPORT or a board reload.

Test Plan:
- 5x5, reset, then in_place with in_mines=25'h1000051 (mines at 0,4,6,24) → WAIT, out_mines=25'h1000051, score 0.
  - Reveal 1 → out_n_valid exactly 10 cycles after accept, out_n_nearby=2, out_score=1, out_cleared bit1 set.
- Same board, reveal 5 → out_n_nearby=2; the edge check fails if 3 (cell 4 counted via wrap).
  - Reveal 12 → 1; reveal 20 → 0.
- Same board: flag 7 then reveal 7 → out_err pulse, no state change.
  - Flag 7 again (unflag) then reveal 7 → accepted.
  - Reveal 1 again (already cleared) → out_err.
  - in_data=25 → out_err.
- Same board, reveal 24 → LOST, out_gameover=1, score unchanged; further in_data_in is ignored.
  - in_place with a new map → WAIT, masks cleared.
- ROWS=COLS=3, mine at 4 only: reveal 0,1,2,3,5,6,7,8 → each out_n_nearby=1.
  - After the 8th REPORT → WON, out_win=1, out_score=8.
- Assert in_restart in the 4th SCAN cycle → next cycle IDLE and all outputs 0.
  - Subsequent in_data_in is ignored until in_place.

Source files
------------

// File: rtl/mines_board_engine.sv
// Minesweeper board engine for a generic ROWS x COLS board: latches the mine map,
// handles flag/reveal guesses, counts neighbours one per cycle, and tracks score, loss and win.
module mines_board_engine #(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int SCORE_W = 32
) (
  input  logic                              in_clka,
  input  logic                              in_restart,
  input  logic                              in_place,
  input  logic [ROWS*COLS-1:0]              in_mines,
  input  logic                              in_data_in,
  input  logic [$clog2(ROWS*COLS)-1:0]      in_data,
  input  logic                              in_flag,
  output logic [2:0]                        out_state,
  output logic                              out_ready,
  output logic [ROWS*COLS-1:0]              out_mines,
  output logic [ROWS*COLS-1:0]              out_cleared,
  output logic [ROWS*COLS-1:0]              out_flagged,
  output logic [3:0]                        out_n_nearby,
  output logic                              out_n_valid,
  output logic                              out_err,
  output logic [SCORE_W-1:0]                out_score,
  output logic                              out_gameover,
  output logic                              out_win
);

  // state  | meaning
  // IDLE   | no board loaded, waiting for in_place
  // WAIT   | board live, accepting one guess
  // CHECK  | reveal the latched cell, test for a mine
  // SCAN   | visit the 8 neighbours, one per cycle
  // REPORT | present neighbour count, decide win
  // LOST   | mine revealed, board frozen
  // WON    | every safe cell revealed, board frozen

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_SCAN   = 3'd3,
    S_REPORT = 3'd4,
    S_LOST   = 3'd5,
    S_WON    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       mines_q, cleared_q, flagged_q;
  logic [3:0]         n_nearby_q;
  logic               err_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   mine_total_q;
  logic [IDX_W-1:0]   idx_q;
  logic [4:0]         row_q, col_q;
  logic [2:0]         k_q;
  logic [3:0]         acc_q;

  logic               load;
  logic [CNT_W-1:0]   place_total;
  logic               guess_in_range, guess_cleared, guess_flagged;
  logic               flag_bad, reveal_bad;
  logic               win_cond;
  int                 scan_dr, scan_dc, scan_r, scan_c;
  logic [IDX_W-1:0]   scan_idx;
  logic               scan_hit;

  assign load = in_place && (state_q == S_IDLE || state_q == S_WAIT ||
                             state_q == S_LOST || state_q == S_WON);

  always_comb begin
    place_total = '0;
    for (int i = 0; i < N; i++) begin
      place_total = place_total + CNT_W'(in_mines[i]);
    end
  end

  always_comb begin
    guess_in_range = 32'(in_data) < 32'(N);
    guess_cleared  = 1'b0;
    guess_flagged  = 1'b0;
    if (guess_in_range) begin
      guess_cleared = cleared_q[in_data];
      guess_flagged = flagged_q[in_data];
    end
    flag_bad   = !guess_in_range || guess_cleared;
    reveal_bad = flag_bad || guess_flagged;
  end

  assign win_cond = score_q == (SCORE_W'(N) - SCORE_W'(mine_total_q));

  // Neighbour offset for step k; out-of-board neighbours are clipped, never wrapped.
  always_comb begin
    scan_dr = 0;
    scan_dc = 0;
    case (k_q)
      3'd0:    begin scan_dr = -1; scan_dc = -1; end
      3'd1:    begin scan_dr = -1; scan_dc =  0; end
      3'd2:    begin scan_dr = -1; scan_dc =  1; end
      3'd3:    begin scan_dr =  0; scan_dc = -1; end
      3'd4:    begin scan_dr =  0; scan_dc =  1; end
      3'd5:    begin scan_dr =  1; scan_dc = -1; end
      3'd6:    begin scan_dr =  1; scan_dc =  0; end
      default: begin scan_dr =  1; scan_dc =  1; end
    endcase
    scan_r   = int'(row_q) + scan_dr;
    scan_c   = int'(col_q) + scan_dc;
    scan_idx = '0;
    scan_hit = 1'b0;
    if (scan_r >= 0 && scan_r < ROWS && scan_c >= 0 && scan_c < COLS) begin
      scan_idx = IDX_W'(scan_r * COLS + scan_c);
      scan_hit = mines_q[scan_idx];
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (place_total == CNT_W'(N)) ? S_WON : S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT:   if (in_data_in && !in_flag && !reveal_bad) state_d = S_CHECK;
        S_CHECK:  state_d = mines_q[idx_q] ? S_LOST : S_SCAN;
        S_SCAN:   if (k_q == 3'd7) state_d = S_REPORT;
        S_REPORT: state_d = win_cond ? S_WON : S_WAIT;
        S_IDLE, S_LOST, S_WON: state_d = state_q;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      mines_q      <= '0;
      cleared_q    <= '0;
      flagged_q    <= '0;
      n_nearby_q   <= '0;
      err_q        <= 1'b0;
      score_q      <= '0;
      mine_total_q <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
    end else begin
      err_q <= 1'b0;
      if (load) begin
        mines_q      <= in_mines;
        mine_total_q <= place_total;
        cleared_q    <= '0;
        flagged_q    <= '0;
        score_q      <= '0;
        n_nearby_q   <= '0;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (in_data_in) begin
              if (in_flag) begin
                if (flag_bad) err_q <= 1'b1;
                else          flagged_q[in_data] <= ~flagged_q[in_data];
              end else if (reveal_bad) begin
                err_q <= 1'b1;
              end else begin
                idx_q <= in_data;
                row_q <= 5'(32'(in_data) / COLS);
                col_q <= 5'(32'(in_data) % COLS);
              end
            end
          end
          S_CHECK: begin
            cleared_q[idx_q] <= 1'b1;
            if (!mines_q[idx_q]) begin
              if (score_q != '1) score_q <= score_q + SCORE_W'(1);
              acc_q <= '0;
              k_q   <= '0;
            end
          end
          S_SCAN: begin
            acc_q <= acc_q + 4'(scan_hit);
            k_q   <= k_q + 3'd1;
            if (k_q == 3'd7) n_nearby_q <= acc_q + 4'(scan_hit);
          end
          default: ;
        endcase
      end
    end
  end

  assign out_state    = state_q;
  assign out_ready    = state_q == S_WAIT;
  assign out_mines    = mines_q;
  assign out_cleared  = cleared_q;
  assign out_flagged  = flagged_q;
  assign out_n_nearby = n_nearby_q;
  assign out_n_valid  = state_q == S_REPORT;
  assign out_err      = err_q;
  assign out_score    = score_q;
  assign out_gameover = state_q == S_LOST;
  assign out_win      = state_q == S_WON;

endmodule
